pipeline_result_sink: RTL and testbench

//   Downstream consumer for the 4-stage pipelined adder output port. Accepts
//   {carry_out,sum_out} when the adder asserts validout and drives the adder's
//   out_allow backpressure. Buffers results in a FWFT FIFO, tags each with a

---
 rtl/pipeline_result_sink_if.sv | 24 ++
 rtl/pipeline_result_sink.sv | 101 ++++++++++
 tb/tb_pipeline_result_sink.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_result_sink_if.sv
// Result handshake between the pipelined adder output port and its sink.
// The adder is the master; the sink drives out_allow back to it.
interface pipeline_result_sink_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_sum;
  logic              in_carry;
  logic              out_allow;

  modport master (
    output in_valid,
    output in_sum,
    output in_carry,
    input  out_allow
  );

  modport slave (
    input  in_valid,
    input  in_sum,
    input  in_carry,
    output out_allow
  );
endinterface

// File: rtl/pipeline_result_sink.sv
// Adder result sink: FWFT FIFO with sequence tags and a running accumulator.
// Backpressure is decoded from the registered count only.
module pipeline_result_sink #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8,
  parameter int ACC_W  = 48,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int ENT_W = DATA_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_result_sink_if.slave up,
  input  logic                 clear,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [ENT_W-1:0]     rd_data,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic [ACC_W-1:0]     acc
);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [TAG_W-1:0] tmem_q [DEPTH];
  logic [TAG_W-1:0] tmem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             push, pop;
  logic [ENT_W-1:0] entry;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign up.out_allow = !full;
  assign rd_valid     = !empty;
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_tag       = rd_valid ? tmem_q[rd_ptr_q] : '0;
  assign count        = count_q;
  assign acc          = acc_q;
  assign entry        = {up.in_carry, up.in_sum};

  // clear suppresses both transfers; rst overrides everything in the flops
  assign push = up.in_valid && !full && !clear;
  assign pop  = rd_en && !empty && !clear;

  always_comb begin
    mem_d    = mem_q;
    tmem_d   = tmem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    acc_d    = acc_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q]  = entry;
        tmem_d[wr_ptr_q] = tag_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        tag_d    = tag_q + TAG_W'(1);
        acc_d    = acc_q + ACC_W'(entry);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        tmem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      tmem_q   <= tmem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_pipeline_result_sink.sv
// Bench for pipeline_result_sink: directed vector table, streaming run,
// and random traffic against a queue-based reference model.
module tb_pipeline_result_sink;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 8;
  localparam int ACC_W  = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clear, rd_en;
  logic              rd_valid, full, empty;
  logic [DATA_W:0]   rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic [2:0]        count;
  logic [ACC_W-1:0]  acc;

  pipeline_result_sink_if #(.DATA_W(DATA_W)) up ();

  pipeline_result_sink #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .clear(clear), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .count(count), .full(full), .empty(empty), .acc(acc)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: queue of entries, tag counter, accumulator
  typedef struct {
    logic [DATA_W:0]  d;
    logic [TAG_W-1:0] t;
  } ent_t;
  ent_t             mq[$];
  int               m_tag;
  logic [ACC_W-1:0] m_acc;

  task automatic model_step(bit r, bit c, bit v, bit cy,
                            logic [DATA_W-1:0] s, bit re);
    bit   p, q;
    ent_t e;
    if (r) begin
      mq.delete();
      m_tag = 0;
      m_acc = '0;
    end else if (c) begin
      mq.delete();
    end else begin
      p = v && (mq.size() < DEPTH);
      q = re && (mq.size() > 0);
      if (q) void'(mq.pop_front());
      if (p) begin
        e.d = {cy, s};
        e.t = m_tag[TAG_W-1:0];
        mq.push_back(e);
        m_tag = (m_tag + 1) % (1 << TAG_W);
        m_acc = m_acc + {{(ACC_W-DATA_W-1){1'b0}}, cy, s};
      end
    end
  endtask

  task automatic model_check(string tagname);
    int n;
    n = mq.size();
    chk({tagname, ".count"}, 64'(count), 64'(n));
    chk({tagname, ".allow"}, 64'(up.out_allow), 64'(n < DEPTH));
    chk({tagname, ".full"}, 64'(full), 64'(n == DEPTH));
    chk({tagname, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tagname, ".rd_valid"}, 64'(rd_valid), 64'(n > 0));
    chk({tagname, ".rd_data"}, 64'(rd_data), n > 0 ? 64'(mq[0].d) : 64'd0);
    chk({tagname, ".rd_tag"}, 64'(rd_tag), n > 0 ? 64'(mq[0].t) : 64'd0);
    chk({tagname, ".acc"}, 64'(acc), 64'(m_acc));
  endtask

  // drive inputs away from the edge, step the model at the edge
  task automatic cycle(bit r, bit c, bit v, bit cy,
                       logic [DATA_W-1:0] s, bit re);
    @(negedge clk);
    rst = r; clear = c; rd_en = re;
    up.in_valid = v; up.in_carry = cy; up.in_sum = s;
    @(posedge clk);
    model_step(r, c, v, cy, s, re);
    #1;
  endtask

  typedef struct {
    bit               r, c, v, cy, re;
    logic [31:0]      s;
    int               cnt;
    logic [32:0]      d;
    logic [7:0]       t;
    logic [47:0]      a;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit c, bit v, bit cy, logic [31:0] s,
                              bit re, int cnt, logic [32:0] d,
                              logic [7:0] t, logic [47:0] a);
    vec_t x;
    x.r = r; x.c = c; x.v = v; x.cy = cy; x.s = s; x.re = re;
    x.cnt = cnt; x.d = d; x.t = t; x.a = a;
    return x;
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; rd_en = 1'b0;
    up.in_valid = 1'b0; up.in_carry = 1'b0; up.in_sum = '0;

    //        r  c  v  cy s             re cnt data            tag  acc
    tbl.push_back(mk(1, 0, 0, 0, 32'd0, 0, 0, 33'd0, 8'd0, 48'd0));
    tbl.push_back(mk(0, 0, 1, 0, 32'd1, 0, 1, 33'd1, 8'd0, 48'd1));
    tbl.push_back(mk(0, 0, 1, 0, 32'd2, 0, 2, 33'd1, 8'd0, 48'd3));
    tbl.push_back(mk(0, 0, 1, 0, 32'd3, 0, 3, 33'd1, 8'd0, 48'd6));
    tbl.push_back(mk(0, 0, 1, 0, 32'd4, 0, 4, 33'd1, 8'd0, 48'd10));
    tbl.push_back(mk(0, 0, 1, 0, 32'd5, 0, 4, 33'd1, 8'd0, 48'd10));
    tbl.push_back(mk(0, 0, 1, 0, 32'd5, 0, 4, 33'd1, 8'd0, 48'd10));
    tbl.push_back(mk(0, 0, 1, 0, 32'd5, 0, 4, 33'd1, 8'd0, 48'd10));
    tbl.push_back(mk(0, 0, 1, 0, 32'd5, 1, 3, 33'd2, 8'd1, 48'd10));
    tbl.push_back(mk(0, 0, 1, 0, 32'd5, 0, 4, 33'd2, 8'd1, 48'd15));
    tbl.push_back(mk(1, 0, 0, 0, 32'd0, 0, 0, 33'd0, 8'd0, 48'd0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFF, 1, 1,
                     33'h1_FFFF_FFFF, 8'd0, 48'h1_FFFF_FFFF));
    tbl.push_back(mk(0, 0, 1, 0, 32'd2, 0, 2,
                     33'h1_FFFF_FFFF, 8'd0, 48'h2_0000_0001));
    tbl.push_back(mk(0, 0, 1, 0, 32'd3, 0, 3,
                     33'h1_FFFF_FFFF, 8'd0, 48'h2_0000_0004));
    tbl.push_back(mk(0, 1, 1, 0, 32'd7, 0, 0, 33'd0, 8'd0, 48'h2_0000_0004));
    tbl.push_back(mk(0, 0, 1, 0, 32'd9, 0, 1, 33'd9, 8'd3, 48'h2_0000_000D));
    tbl.push_back(mk(1, 1, 1, 0, 32'd8, 0, 0, 33'd0, 8'd0, 48'd0));
    tbl.push_back(mk(0, 0, 1, 0, 32'd6, 0, 1, 33'd6, 8'd0, 48'd6));

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cycle(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].cy, tbl[i].s, tbl[i].re);
      chk({nm, ".count"}, 64'(count), 64'(tbl[i].cnt));
      chk({nm, ".allow"}, 64'(up.out_allow), 64'(tbl[i].cnt != DEPTH));
      chk({nm, ".full"}, 64'(full), 64'(tbl[i].cnt == DEPTH));
      chk({nm, ".empty"}, 64'(empty), 64'(tbl[i].cnt == 0));
      chk({nm, ".rd_valid"}, 64'(rd_valid), 64'(tbl[i].cnt != 0));
      chk({nm, ".rd_data"}, 64'(rd_data), 64'(tbl[i].d));
      chk({nm, ".rd_tag"}, 64'(rd_tag), 64'(tbl[i].t));
      chk({nm, ".acc"}, 64'(acc), 64'(tbl[i].a));
    end

    // streaming: half full, then push+pop every cycle across a tag wrap
    cycle(1, 0, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'd1000, 0);
    cycle(0, 0, 1, 0, 32'd1001, 0);
    begin
      int exp_tag;
      logic [DATA_W:0] exp_d;
      exp_tag = 0;
      exp_d   = 33'd1000;
      for (int i = 0; i < 300; i++) begin
        // the word about to be popped must follow write order
        chk("stream.tag", 64'(rd_tag), 64'(exp_tag % 256));
        chk("stream.data", 64'(rd_data), 64'(exp_d));
        cycle(0, 0, 1, 0, 32'(1002 + i), 1);
        chk("stream.count", 64'(count), 64'd2);
        exp_tag++;
        exp_d++;
      end
      model_check("stream");
    end

    // random traffic against the reference model
    cycle(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, c, v, cy, re;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 99) < 60);
      re = ($urandom_range(0, 99) < 50);
      cy = $urandom_range(0, 1);
      cycle(r, c, v, cy, $urandom, re);
      model_check($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
